// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: integer (x, y) in, integer magnitude and
// atan2(y, x) in degrees out, one micro-rotation per clock.
module cordic_vectoring #(
  parameter int VEC_WIDTH         = 8,
  parameter int ANG_WIDTH         = 9,
  parameter int VEC_PROCESS_WIDTH = 16,
  parameter int ANG_PROCESS_WIDTH = 16,
  parameter int ITERATIONS        = 12,
  parameter int ANG_TABLE_WIDTH   = ANG_PROCESS_WIDTH - 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [VEC_WIDTH-1:0] i_x,
  input  logic [VEC_WIDTH-1:0] i_y,
  output logic [VEC_WIDTH:0]   o_mag,
  output logic [ANG_WIDTH-1:0] o_angle,
  output logic                 o_done
);

  // state | meaning
  // IDLE  | waiting for i_start, inputs latched on start
  // PRE   | scale inputs, fold left half-plane into right, seed z
  // ITER  | one micro-rotation per cycle, ITERATIONS cycles
  // POST  | gain-correct magnitude, round angle, pulse o_done

  localparam int PW        = VEC_PROCESS_WIDTH;
  localparam int AW        = ANG_PROCESS_WIDTH;
  localparam int VEC_FRAC  = PW - VEC_WIDTH - 2;
  localparam int ANG_FRAC  = AW - ANG_WIDTH;
  localparam int CNT_W     = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam int PRODW     = PW + 17;
  localparam int ATAN_SHL  = (ANG_FRAC >= 7) ? ANG_FRAC - 7 : 0;
  localparam int ATAN_SHR  = (ANG_FRAC < 7) ? 7 - ANG_FRAC : 0;
  localparam int GAIN_K    = 19898;

  localparam logic signed [AW-1:0]    Z180      = AW'(180 << ANG_FRAC);
  localparam logic signed [AW:0]      ANG_HALF  = (AW+1)'(1 << (ANG_FRAC - 1));
  localparam logic signed [AW:0]      ANG_MAX   = (AW+1)'(180);
  localparam logic signed [AW:0]      ANG_MIN   = -(AW+1)'(180);
  localparam logic signed [PRODW-1:0] MAG_HALF  = PRODW'(1 << (14 + VEC_FRAC));
  localparam logic signed [PRODW-1:0] MAG_MAX   = PRODW'((1 << (VEC_WIDTH + 1)) - 1);
  localparam logic signed [PRODW-1:0] GAIN      = PRODW'(GAIN_K);
  localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(ITERATIONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_POST} state_t;

  // atan(2^-i) in degrees x 2^7, rounded to nearest
  function automatic logic [ANG_TABLE_WIDTH-1:0] atan_entry(input int idx);
    int unsigned base;
    case (idx)
      0:       base = 5760;
      1:       base = 3400;
      2:       base = 1797;
      3:       base = 912;
      4:       base = 458;
      5:       base = 229;
      6:       base = 115;
      7:       base = 57;
      8:       base = 29;
      9:       base = 14;
      10:      base = 7;
      11:      base = 4;
      12:      base = 2;
      13:      base = 1;
      default: base = 0;
    endcase
    return ANG_TABLE_WIDTH'((base << ATAN_SHL) >> ATAN_SHR);
  endfunction

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [PW-1:0]    x_q, y_q;
  logic signed [AW-1:0]    z_q;
  logic                    zero_q;
  logic [VEC_WIDTH:0]      mag_q;
  logic [ANG_WIDTH-1:0]    angle_q;
  logic                    done_q;

  logic signed [PW-1:0]    x_pre_d, y_pre_d, x_iter_d, y_iter_d;
  logic signed [AW-1:0]    z_pre_d, z_iter_d, atan_s;
  logic signed [PRODW-1:0] prod, mag_full;
  logic signed [AW:0]      z_rnd, ang_full;
  logic [VEC_WIDTH:0]      mag_d;
  logic [ANG_WIDTH-1:0]    angle_d;

  always_comb begin
    x_pre_d = x_q <<< VEC_FRAC;
    y_pre_d = y_q <<< VEC_FRAC;
    z_pre_d = '0;
    // Left half-plane: rotate by 180 so the iterations only see |angle| <= 90
    if (x_q < 0) begin
      x_pre_d = -(x_q <<< VEC_FRAC);
      y_pre_d = -(y_q <<< VEC_FRAC);
      z_pre_d = (y_q >= 0) ? Z180 : -Z180;
    end
  end

  always_comb begin
    atan_s = AW'(atan_entry(int'(cnt_q)));
    if (y_q >= 0) begin
      x_iter_d = x_q + (y_q >>> cnt_q);
      y_iter_d = y_q - (x_q >>> cnt_q);
      z_iter_d = z_q + atan_s;
    end else begin
      x_iter_d = x_q - (y_q >>> cnt_q);
      y_iter_d = y_q + (x_q >>> cnt_q);
      z_iter_d = z_q - atan_s;
    end
  end

  always_comb begin
    prod     = $signed({{(PRODW-PW){x_q[PW-1]}}, x_q}) * GAIN;
    mag_full = (prod + MAG_HALF) >>> (15 + VEC_FRAC);
    if (mag_full < 0)            mag_d = '0;
    else if (mag_full > MAG_MAX) mag_d = MAG_MAX[VEC_WIDTH:0];
    else                         mag_d = mag_full[VEC_WIDTH:0];

    z_rnd    = $signed({z_q[AW-1], z_q}) + ANG_HALF;
    ang_full = z_rnd >>> ANG_FRAC;
    if (ang_full > ANG_MAX)      angle_d = ANG_MAX[ANG_WIDTH-1:0];
    else if (ang_full < ANG_MIN) angle_d = ANG_MIN[ANG_WIDTH-1:0];
    else                         angle_d = ang_full[ANG_WIDTH-1:0];

    if (zero_q) begin
      mag_d   = '0;
      angle_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      angle_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            x_q     <= {{(PW-VEC_WIDTH){i_x[VEC_WIDTH-1]}}, i_x};
            y_q     <= {{(PW-VEC_WIDTH){i_y[VEC_WIDTH-1]}}, i_y};
            state_q <= S_PRE;
          end
        end
        S_PRE: begin
          zero_q  <= (x_q == 0) && (y_q == 0);
          x_q     <= x_pre_d;
          y_q     <= y_pre_d;
          z_q     <= z_pre_d;
          cnt_q   <= '0;
          state_q <= S_ITER;
        end
        S_ITER: begin
          x_q <= x_iter_d;
          y_q <= y_iter_d;
          z_q <= z_iter_d;
          if (cnt_q == CNT_LAST) state_q <= S_POST;
          else                   cnt_q   <= cnt_q + 1'b1;
        end
        S_POST: begin
          mag_q   <= mag_d;
          angle_q <= angle_d;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_mag   = mag_q;
  assign o_angle = angle_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring: magnitude/angle, latency, back-to-back,
// output hold and asynchronous reset abort.
module tb_cordic_vectoring;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic signed [7:0] xi, yi;
  logic [8:0]        o_mag;
  logic [8:0]        o_angle;
  logic              o_done;

  int n_checks = 0;
  int n_errors = 0;

  cordic_vectoring dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_x    (xi),
    .i_y    (yi),
    .o_mag  (o_mag),
    .o_angle(o_angle),
    .o_done (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
    n_checks++;
    if (obs - exp > tol || exp - obs > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int ang_i();
    return int'($signed(o_angle));
  endfunction

  task automatic run_vec(input int x, input int y, input int em, input int ea,
                         input int tm, input int ta, input string tag);
    int c;
    bit seen;
    @(negedge clk);
    xi = 8'(x);
    yi = 8'(y);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 0;
    seen = 1'b0;
    while (!seen && c < 40) begin
      @(posedge clk);
      c++;
      #1 if (o_done) seen = 1'b1;
    end
    check({tag, "_latency"}, c, 14);
    check({tag, "_mag"}, int'(o_mag), em, tm);
    check({tag, "_angle"}, ang_i(), ea, ta);
    @(posedge clk);
    #1 check({tag, "_pulse_end"}, int'(o_done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int nd;
    rst_n = 1'b0;
    start = 1'b0;
    xi = '0;
    yi = '0;
    repeat (3) @(negedge clk);
    check("reset_mag", int'(o_mag), 0);
    check("reset_angle", ang_i(), 0);
    check("reset_done", int'(o_done), 0);
    rst_n = 1'b1;

    run_vec(100, 0, 100, 0, 1, 1, "x100");
    run_vec(0, 100, 100, 90, 1, 1, "y100");

    // Outputs must hold while idle even when inputs move
    @(negedge clk);
    xi = -8'sd77;
    yi = 8'sd33;
    repeat (6) @(negedge clk);
    check("hold_mag", int'(o_mag), 100, 1);
    check("hold_angle", ang_i(), 90, 1);

    run_vec(-61, -49, 78, -141, 1, 1, "q3");
    run_vec(-128, 0, 128, 180, 1, 0, "neg_x_axis");
    run_vec(-128, -128, 181, -135, 1, 1, "corner");
    run_vec(0, 0, 0, 0, 0, 0, "zero");

    // Back-to-back with start held high; junk inputs only while busy
    p = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start = (k <= 50);
      if ((k % 15) >= 3 && (k % 15) <= 10) begin
        xi = -8'sd100;
        yi = 8'sd5;
      end else begin
        xi = 8'sd30;
        yi = 8'sd40;
      end
      @(posedge clk);
      #1 if (o_done) begin
        p++;
        check("b2b_edge", k, 15 * p);
        check("b2b_mag", int'(o_mag), 50, 1);
        check("b2b_angle", ang_i(), 53, 1);
      end
    end
    start = 1'b0;
    check("b2b_count", p, 4);

    // Asynchronous reset five cycles into an operation
    @(negedge clk);
    xi = 8'sd100;
    yi = 8'sd0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mag", int'(o_mag), 0);
    check("arst_angle", ang_i(), 0);
    check("arst_done", int'(o_done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1 if (o_done) nd++;
    end
    check("arst_no_done", nd, 0);

    run_vec(100, 0, 100, 0, 1, 1, "post_rst");

    // Rotation-block outputs for (-61,-49) rotated by 32 degrees
    run_vec(-26, -74, 78, -109, 2, 2, "rt_round");
    run_vec(-25, -73, 78, -109, 2, 2, "rt_trunc");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cordic_vectoring.md
Name: cordic_vectoring

Overview:
Iterative CORDIC in vectoring mode; the inverse of the existing rotation block. Takes an integer vector (x, y) and returns its integer magnitude and its integer angle atan2(y, x) in degrees, range -180..180. One micro-rotation per clock. Used to recover polar form from Cartesian samples, and paired with the rotation block for round-trip checks.

Parameters:
VEC_WIDTH, 8, width of signed input components i_x and i_y (integer).
ANG_WIDTH, 9, width of signed output angle (integer degrees).
VEC_PROCESS_WIDTH, 16, internal signed x/y width; VEC_FRAC = VEC_PROCESS_WIDTH - VEC_WIDTH - 2 fractional bits (6 by default).
ANG_PROCESS_WIDTH, 16, internal signed z width; ANG_FRAC = ANG_PROCESS_WIDTH - ANG_WIDTH fractional bits (7 by default).
ITERATIONS, 12, number of micro-rotations.
ANG_TABLE_WIDTH, ANG_PROCESS_WIDTH-1, width of unsigned atan table entries.

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_start  in  1  start request, sampled only in IDLE.
i_x  in  VEC_WIDTH  signed x component (integer).
i_y  in  VEC_WIDTH  signed y component (integer).
o_mag  out  VEC_WIDTH+1  unsigned magnitude (integer).
o_angle  out  ANG_WIDTH  signed angle in degrees (integer), -180..180.
o_done  out  1  one-cycle pulse; o_mag and o_angle are valid.

Behaviour:
- Reset: i_clk and i_rst_n are the only clock and reset; reset is asynchronous and active-low. Reset forces state=IDLE, o_mag=0, o_angle=0, o_done=0, and clears the iteration counter and x/y/z registers. Reset asserted mid-operation aborts the operation; no o_done is produced for it.
- FSM: IDLE -> PRE -> ITER (ITERATIONS cycles) -> POST -> IDLE.
- IDLE: on an edge with i_start=1, latch i_x and i_y, then go to PRE. i_start is ignored in every other state.
- PRE (1 cycle): sign-extend inputs and shift them left by VEC_FRAC.
  - If x<0: x=-x, y=-y, z0 = +180<<ANG_FRAC when original y>=0, otherwise -180<<ANG_FRAC.
  - Otherwise z0=0.
  - Clear counter i.
- ITER, step i:
  - If y>=0: x += y>>>i, y -= x>>>i, z += atan[i].
  - Otherwise: x -= y>>>i, y += x>>>i, z -= atan[i].
  - All updates use the old x and y values. Shifts are arithmetic.
  - After i = ITERATIONS-1, go to POST.
- atan table (degrees x 2^7, default widths): 5760, 3400, 1797, 912, 458, 229, 115, 57, 29, 14, 7, 4. Entries are rounded to nearest.
- POST (1 cycle):
  - Magnitude: mag = (x * K + 2^(14+VEC_FRAC)) >>> (15+VEC_FRAC), with K = 19898 (0.60725 in Q0.15). Saturate mag to 2^(VEC_WIDTH+1)-1.
  - Angle: o_angle = (z + 2^(ANG_FRAC-1)) >>> ANG_FRAC. Clamp o_angle to [-180, 180].
  - Register o_mag and o_angle, set o_done=1, go to IDLE.
- Zero vector: if the latched x=0 and y=0, POST forces o_mag=0 and o_angle=0.
- Latency: i_start sampled at edge N gives o_done=1 for exactly the one cycle after edge N+ITERATIONS+2 (14 cycles by default).
- Output hold: o_mag and o_angle keep their values until the next POST.
- Back-to-back: if i_start is held high, the next start is sampled in the IDLE cycle where o_done=1. Throughput is one result per ITERATIONS+3 cycles.
- Width rule: internal x must hold 1.647*sqrt(2)*128 ≈ 298 plus sign; VEC_PROCESS_WIDTH=16 with 6 fractional bits suffices, and no internal overflow is permitted.

Test Plan:
- Reset, then i_x=100, i_y=0, start -> o_done 14 cycles after start; o_mag=100±1, o_angle=0±1.
- i_x=0, i_y=100 -> o_mag=100±1, o_angle=90±1. Then i_x=-61, i_y=-49 -> o_mag=78±1, o_angle=-141±1.
- Boundaries:
  - i_x=-128, i_y=0 -> o_mag=128±1, o_angle=180 (never -180).
  - i_x=-128, i_y=-128 -> o_mag=181±1, o_angle=-135±1.
  - i_x=0, i_y=0 -> o_mag=0, o_angle=0.
- i_start held high for 50 cycles, inputs fixed at (30,40) -> o_done pulses every 15 cycles, each with o_mag=50±1 and o_angle=53±1. Changing inputs mid-operation has no effect on the current result.
- Assert i_rst_n=0 at cycle 5 of an operation -> all outputs 0 immediately with no clock edge needed, no o_done follows, and the next start completes normally.
- Round trip: feed each output of the rotation block (input (-61,-49) rotated by 32) into this block -> o_mag=78±2, o_angle=-109±2.
